rx_iod_bit_align_mlane: RTL and testbench



---
 rtl/rx_align_pkg.sv | 27 ++
 rtl/rx_eye_tracker.sv | 55 +++++
 rtl/rx_iod_bit_align_mlane.sv | 180 ++++++++++++++++++
 tb/tb_rx_iod_bit_align_mlane.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_align_pkg.sv
// Shared types and helpers for the multi-lane RX IOD bit aligner.
// FSM state encoding plus settle-count and eye-centre arithmetic.
package rx_align_pkg;

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_LOAD,
    S_CLR,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_EVAL,
    S_CENTER,
    S_GAP,
    S_NEXT,
    S_DONE
  } align_state_t;

  function automatic int settle_cycles(input int w);
    return 1 << w;
  endfunction

  function automatic int eye_centre(input int start, input int len);
    return start + (len >> 1);
  endfunction

endpackage

// File: rtl/rx_eye_tracker.sv
// Tracks the current and widest clean tap window during one lane sweep.
// Best outputs already include the final compare so EVAL sees it at once.
module rx_eye_tracker
  import rx_align_pkg::*;
#(
  parameter int TAP_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic             clean,
  input  logic [TAP_W-1:0] tap,
  input  logic             final_cmp,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] cur_start;
  logic [TAP_W-1:0] best_start_q;
  logic [TAP_W:0]   cur_len;
  logic [TAP_W:0]   best_len_q;
  logic             cur_wins;

  // strict compare: an equal later window never replaces the earlier one
  assign cur_wins = cur_len > best_len_q;

  assign best_start = (final_cmp && cur_wins) ? cur_start : best_start_q;
  assign best_len   = (final_cmp && cur_wins) ? cur_len : best_len_q;

  // window bookkeeping, one update per sampled tap
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_start    <= '0;
      cur_len      <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (sample_valid) begin
      if (clean) begin
        if (cur_len == '0) cur_start <= tap;
        cur_len <= cur_len + 1'b1;
      end else begin
        if (cur_wins) begin
          best_start_q <= cur_start;
          best_len_q   <= cur_len;
        end
        cur_len <= '0;
      end
    end else if (final_cmp && cur_wins) begin
      best_start_q <= cur_start;
      best_len_q   <= cur_len;
    end
  end

endmodule

// File: rtl/rx_iod_bit_align_mlane.sv
// Multi-lane IOD bit aligner: sweeps taps, finds widest eye, parks at centre.
// Optional freeze via RX_ALIGN_HOLD_EN (ALGN_HOLD ignored when undefined).
module rx_iod_bit_align_mlane
  import rx_align_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int NUM_TAPS       = 128,
  parameter int WAIT_CNT_WIDTH = 3,
  parameter int MIN_EYE        = 8
) (
  input  logic                                 SCLK,
  input  logic                                 RESET,
  input  logic                                 PLL_LOCK,
  input  logic                                 ALGN_RSTRT,
  input  logic                                 ALGN_HOLD,
  input  logic [NUM_LANES-1:0]                 IOD_EARLY,
  input  logic [NUM_LANES-1:0]                 IOD_LATE,
  output logic [NUM_LANES-1:0]                 ALGN_LOAD,
  output logic [NUM_LANES-1:0]                 ALGN_MOVE,
  output logic                                 ALGN_DIR,
  output logic [NUM_LANES-1:0]                 ALGN_CLR_FLGS,
  output logic                                 ALGN_BUSY,
  output logic                                 ALGN_DONE,
  output logic                                 ALGN_ERR,
  output logic [NUM_LANES-1:0]                 LANE_ERR,
  output logic [NUM_LANES*$clog2(NUM_TAPS)-1:0] TAP_VAL
);

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [WAIT_CNT_WIDTH-1:0] SETTLE_LAST =
    WAIT_CNT_WIDTH'(settle_cycles(WAIT_CNT_WIDTH) - 1);

  align_state_t state_q, state_d;

  logic [LANE_W-1:0]          lane_q;
  logic [TAP_W-1:0]           tap_q;
  logic [WAIT_CNT_WIDTH-1:0]  wait_q;
  logic [TAP_W:0]             move_q;
  logic [NUM_LANES*TAP_W-1:0] tap_val_q;
  logic [NUM_LANES-1:0]       lane_err_q;
  logic [NUM_LANES-1:0]       lane_oh;

  logic             frz;
  logic             act;
  logic             load_p, move_p, clr_p, dir_p;
  logic             clean;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;
  logic [TAP_W:0]   centre;
  logic [TAP_W:0]   move_w;
  logic             eye_ok;

`ifdef RX_ALIGN_HOLD_EN
  assign frz = ALGN_HOLD;
`else
  logic unused_hold;
  assign unused_hold = ALGN_HOLD;
  assign frz = 1'b0;
`endif

  assign act     = PLL_LOCK & ~frz;
  assign lane_oh = NUM_LANES'(1) << lane_q;
  assign clean   = ~(IOD_EARLY[lane_q] | IOD_LATE[lane_q]);
  assign eye_ok  = best_len >= (TAP_W+1)'(MIN_EYE);
  assign centre  = (TAP_W+1)'(eye_centre(int'(best_start), int'(best_len)));
  assign move_w  = (TAP_W+1)'(NUM_TAPS - 1) - centre;

  rx_eye_tracker #(.TAP_W(TAP_W)) u_eye (
    .clk          (SCLK),
    .rst          (RESET),
    .clear        (act && state_q == S_LOAD),
    .sample_valid (act && state_q == S_SAMPLE),
    .clean        (clean),
    .tap          (tap_q),
    .final_cmp    (act && state_q == S_EVAL),
    .best_start   (best_start),
    .best_len     (best_len)
  );

  // next state and per-state pulse requests; lock, restart, hold override
  always_comb begin
    state_d = state_q;
    load_p  = 1'b0;
    move_p  = 1'b0;
    clr_p   = 1'b0;
    dir_p   = 1'b0;
    unique case (state_q)
      S_WAIT_LOCK: if (PLL_LOCK) state_d = S_LOAD;
      S_LOAD: begin
        load_p  = 1'b1;
        state_d = S_CLR;
      end
      S_CLR: begin
        clr_p   = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (wait_q == SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE:
        state_d = (tap_q == TAP_W'(NUM_TAPS - 1)) ? S_EVAL : S_STEP;
      S_STEP: begin
        move_p  = 1'b1;
        dir_p   = 1'b1;
        state_d = S_CLR;
      end
      S_EVAL: begin
        if (!eye_ok) begin
          load_p  = 1'b1;
          state_d = S_NEXT;
        end else begin
          state_d = (move_w == '0) ? S_NEXT : S_CENTER;
        end
      end
      S_CENTER: begin
        move_p  = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: if (move_q == '0) state_d = S_NEXT;
             else state_d = S_CENTER;
      S_NEXT:
        state_d = (lane_q == LANE_W'(NUM_LANES - 1)) ? S_DONE : S_LOAD;
      S_DONE: state_d = S_DONE;
      default: state_d = S_WAIT_LOCK;
    endcase
    if (frz) state_d = state_q;
    if (ALGN_RSTRT) state_d = PLL_LOCK ? S_LOAD : S_WAIT_LOCK;
    if (!PLL_LOCK) state_d = S_WAIT_LOCK;
  end

  // state register, sweep counters and per-lane results
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q    <= S_WAIT_LOCK;
      lane_q     <= '0;
      tap_q      <= '0;
      wait_q     <= '0;
      move_q     <= '0;
      tap_val_q  <= '0;
      lane_err_q <= '0;
    end else begin
      state_q <= state_d;
      if (!PLL_LOCK || ALGN_RSTRT) begin
        lane_q     <= '0;
        tap_val_q  <= '0;
        lane_err_q <= '0;
      end else if (act) begin
        unique case (state_q)
          S_LOAD:   tap_q <= '0;
          S_CLR:    wait_q <= '0;
          S_SETTLE: wait_q <= wait_q + 1'b1;
          S_STEP:   tap_q <= tap_q + 1'b1;
          S_EVAL: begin
            if (!eye_ok) begin
              lane_err_q[lane_q] <= 1'b1;
              tap_val_q[lane_q*TAP_W +: TAP_W] <= '0;
            end else begin
              tap_val_q[lane_q*TAP_W +: TAP_W] <= centre[TAP_W-1:0];
              move_q <= move_w;
            end
          end
          S_CENTER: move_q <= move_q - 1'b1;
          S_NEXT:
            if (lane_q != LANE_W'(NUM_LANES - 1)) lane_q <= lane_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign ALGN_LOAD     = (act && load_p) ? lane_oh : '0;
  assign ALGN_MOVE     = (act && move_p) ? lane_oh : '0;
  assign ALGN_CLR_FLGS = (act && clr_p) ? lane_oh : '0;
  assign ALGN_DIR      = act & dir_p;
  assign ALGN_BUSY     = (state_q != S_WAIT_LOCK) && (state_q != S_DONE);
  assign ALGN_DONE     = state_q == S_DONE;
  assign LANE_ERR      = lane_err_q;
  assign ALGN_ERR      = |lane_err_q;
  assign TAP_VAL       = tap_val_q;

endmodule

// File: tb/tb_rx_iod_bit_align_mlane.sv
// Bench for rx_iod_bit_align_mlane: per-lane IOD delay/eye model,
// reference eye search, scoreboard checked when DONE rises.
module tb_rx_iod_bit_align_mlane;

  localparam int NL = 2;
  localparam int NT = 16;
  localparam int TW = 4;
  localparam int WW = 2;
  localparam int ME = 4;
`ifdef RX_ALIGN_HOLD_EN
  localparam int HOLD_EXTRA = 10;
`else
  localparam int HOLD_EXTRA = 0;
`endif

  logic          sclk = 1'b0;
  logic          rst, lock, rstrt, hold;
  logic [NL-1:0] early, late;
  logic [NL-1:0] load, move, clr, lerr;
  logic          dir, busy, done, err;
  logic [NL*TW-1:0] tapv;

  always #5 sclk = ~sclk;

  rx_iod_bit_align_mlane #(
    .NUM_LANES(NL), .NUM_TAPS(NT), .WAIT_CNT_WIDTH(WW), .MIN_EYE(ME)
  ) dut (
    .SCLK(sclk), .RESET(rst), .PLL_LOCK(lock), .ALGN_RSTRT(rstrt),
    .ALGN_HOLD(hold), .IOD_EARLY(early), .IOD_LATE(late),
    .ALGN_LOAD(load), .ALGN_MOVE(move), .ALGN_DIR(dir),
    .ALGN_CLR_FLGS(clr), .ALGN_BUSY(busy), .ALGN_DONE(done),
    .ALGN_ERR(err), .LANE_ERR(lerr), .TAP_VAL(tapv)
  );

  typedef struct {
    int tap;
    bit err;
    int moves;
    int cyc;
  } exp_t;

  exp_t          sbq[$];
  logic [NT-1:0] mask [NL];
  int            pos [NL];
  int            dec [NL];
  int            checks = 0;
  int            passes = 0;
  int            done_cnt = 0;
  int            multi_bad = 0;
  int            t_load0 = -1;
  int            t_load1 = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  function automatic logic [NT-1:0] win(input int lo, input int hi);
    logic [NT-1:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // widest run of clean taps, first one on ties, then eye centre
  function automatic exp_t ref_lane(input logic [NT-1:0] m,
                                    input bit first, input int extra);
    int bs = 0, bl = 0, run = 0, rs = 0;
    exp_t e;
    for (int t = 0; t < NT; t++) begin
      if (m[t]) begin
        if (run == 0) rs = t;
        run++;
        if (run > bl) begin
          bl = run;
          bs = rs;
        end
      end else run = 0;
    end
    e.err   = bl < ME;
    e.tap   = e.err ? 0 : bs + bl / 2;
    e.moves = e.err ? 0 : NT - 1 - e.tap;
    e.cyc   = (first && !e.err) ?
              1 + NT * (2 + (1 << WW)) + (NT - 1) + 1 + 2 * e.moves + extra
              : -1;
    return e;
  endfunction

  task automatic push_exp(input int extra);
    for (int i = 0; i < NL; i++) sbq.push_back(ref_lane(mask[i], i == 0, extra));
  endtask

  // delay line and flag model: position follows LOAD/MOVE pulses
  always @(negedge sclk) begin : model
    logic [1:0] r;
    for (int i = 0; i < NL; i++) begin
      if (load[i] === 1'b1) pos[i] = 0;
      else if (move[i] === 1'b1) pos[i] = pos[i] + (dir ? 1 : -1);
    end
    for (int i = 0; i < NL; i++) begin
      if (pos[i] >= 0 && pos[i] < NT && mask[i][pos[i]]) begin
        early[i] = 1'b0;
        late[i]  = 1'b0;
      end else begin
        r = 2'($urandom_range(1, 3));
        early[i] = r[0];
        late[i]  = r[1];
      end
    end
  end

  // monitor: pulse bookkeeping and scoreboard compare on DONE rising
  always @(negedge sclk) begin : monitor
    static int  mcyc = 0;
    static bit  done_q = 1'b0;
    exp_t       e;
    bit         experr;
    mcyc++;
    if ($countones({load, move, clr}) > 1) multi_bad++;
    if (load[0] === 1'b1) begin
      t_load0 = mcyc;
      t_load1 = -1;
      dec[0]  = 0;
    end
    if (load[1] === 1'b1) begin
      if (t_load1 < 0) t_load1 = mcyc;
      dec[1] = 0;
    end
    for (int i = 0; i < NL; i++)
      if (move[i] === 1'b1 && dir === 1'b0) dec[i]++;
    if (done === 1'b1 && !done_q) begin
      experr = 1'b0;
      if (sbq.size() < NL) begin
        checks++;
        $display("FAIL scoreboard: DONE with %0d entries, want %0d",
                 sbq.size(), NL);
      end else begin
        for (int i = 0; i < NL; i++) begin
          e = sbq.pop_front();
          experr |= e.err;
          chk($sformatf("tap_val lane%0d", i), int'(tapv[i*TW +: TW]), e.tap);
          chk($sformatf("lane_err lane%0d", i), int'(lerr[i]), int'(e.err));
          chk($sformatf("delay pos lane%0d", i), pos[i], e.tap);
          chk($sformatf("dec moves lane%0d", i), dec[i], e.moves);
          if (i == 0 && e.cyc >= 0)
            chk("lane0 cycles", t_load1 - t_load0 - 1, e.cyc);
        end
        chk("aggregate err", int'(err), int'(experr));
        chk("busy low at done", int'(busy), 0);
      end
      done_cnt++;
    end
    done_q = (done === 1'b1);
  end

  task automatic wait_done(input string name);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 5000) begin
      @(negedge sclk);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      $display("FAIL %s: no DONE within %0d cycles", name, n);
    end
  endtask

  task automatic start_rstrt();
    @(posedge sclk); #1 rstrt = 1'b1;
    @(posedge sclk); #1 rstrt = 1'b0;
    @(negedge sclk);
    chk("rstrt load0", int'(load), 1);
    chk("rstrt clears done/tap", int'({done, tapv, lerr}), 0);
  endtask

  task automatic rand_mask(output logic [NT-1:0] m);
    int nw, lo, hi;
    m  = '0;
    nw = $urandom_range(1, 2);
    for (int w = 0; w < nw; w++) begin
      lo = $urandom_range(0, NT - 1);
      hi = lo + $urandom_range(0, NT - 1);
      if (hi > NT - 1) hi = NT - 1;
      m |= win(lo, hi);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, hc;
    logic [NT-1:0] m;
    rst = 1'b1; lock = 1'b0; rstrt = 1'b0; hold = 1'b0;
    for (int i = 0; i < NL; i++) begin
      pos[i] = 0;
      dec[i] = 0;
      mask[i] = '0;
    end
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
    @(negedge sclk);
    chk("reset outputs",
        int'({load, move, clr, dir, busy, done, err, lerr, tapv}), 0);
    repeat (3) @(negedge sclk);
    chk("idle without lock", int'({busy, load}), 0);

    mask[0] = win(4, 11);
    mask[1] = win(0, 15);
    push_exp(0);
    @(posedge sclk); #1 lock = 1'b1;
    wait_done("scn1 centred");

    mask[0] = win(1, 3) | win(9, 14);
    push_exp(0);
    start_rstrt();
    wait_done("scn2 widest");

    mask[0] = win(2, 5) | win(10, 13);
    push_exp(0);
    start_rstrt();
    wait_done("scn3 tie");

    mask[0] = win(12, 15);
    mask[1] = win(6, 8);
    push_exp(0);
    start_rstrt();
    wait_done("scn4 edge/narrow");

    mask[0] = win(4, 11);
    mask[1] = win(0, 15);
    start_rstrt();
    n = 0;
    while (load[1] !== 1'b1 && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    chk("reached lane1", int'(load[1] === 1'b1), 1);
    repeat (5) @(negedge sclk);
    chk("tap_val0 before drop", int'(tapv[TW-1:0]), 8);
    @(posedge sclk); #1 lock = 1'b0;
    @(negedge sclk);
    chk("drop cycle pulses", int'({load, move}), 0);
    @(negedge sclk);
    chk("drop clears", int'({busy, done, tapv, lerr}), 0);
    push_exp(0);
    @(posedge sclk); #1 lock = 1'b1;
    n = 0;
    while ({load, move, clr} == '0 && n < 20) begin
      @(negedge sclk);
      n++;
    end
    chk("relock first pulse", int'({load, move, clr}), 16);
    wait_done("scn5 relock");

    push_exp(HOLD_EXTRA);
    start_rstrt();
    n = 0;
    while (clr[0] !== 1'b1 && n < 50) begin
      @(negedge sclk);
      n++;
    end
    @(posedge sclk); #1 hold = 1'b1;
    hc = 0;
    repeat (10) begin
      @(negedge sclk);
      if ({load, move, clr} != '0) hc++;
      @(posedge sclk); #1;
    end
    hold = 1'b0;
`ifdef RX_ALIGN_HOLD_EN
    chk("hold no pulses", hc, 0);
`endif
    wait_done("scn6 hold");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NL; i++) begin
        rand_mask(m);
        mask[i] = m;
      end
      push_exp(0);
      start_rstrt();
      wait_done($sformatf("random %0d", k));
    end

    chk("pulse onehot", multi_bad, 0);
    chk("scoreboard drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
